dmux4way16_stream: RTL and testbench

DMUX4WAY16_STREAM -- requirements
Module: dmux4way16_stream

---
 rtl/dmux4way16_stream.sv | 82 ++++++++
 tb/tb_dmux4way16_stream.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux4way16_stream.sv
// 1-to-4 valid/ready stream demux with a 1-entry holding register per channel.
// Define DMUX4WAY16_STREAM_COUNT_EN to enable the per-channel 8-bit accept counters.
module dmux4way16_stream #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2,
  output logic [7:0]       cnt3
);

  logic [WIDTH-1:0] r_data [4];
  logic [3:0]       r_valid;
  logic [3:0]       w_load;
  logic             w_accept;

  assign in_ready = rst | ~r_valid[in_sel] | out_ready[in_sel];
  assign w_accept = in_valid & in_ready & ~rst;

  // in_sel is only decoded once a word is really accepted
  always_comb begin
    w_load = '0;
    if (w_accept) w_load[in_sel] = 1'b1;
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid[g] <= 1'b0;
        r_data[g]  <= '0;
      end else if (w_load[g]) begin
        r_valid[g] <= 1'b1;
        r_data[g]  <= in_data;
      end else if (r_valid[g] && out_ready[g]) begin
        r_valid[g] <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];

`ifdef DMUX4WAY16_STREAM_COUNT_EN
  logic [7:0] r_cnt [4];

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt[g] <= '0;
      end else if (w_load[g]) begin
        r_cnt[g] <= r_cnt[g] + 8'd1;
      end
    end
  end

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
  assign cnt3 = r_cnt[3];
`else
  assign cnt0 = 8'd0;
  assign cnt1 = 8'd0;
  assign cnt2 = 8'd0;
  assign cnt3 = 8'd0;
`endif

endmodule

// File: tb/tb_dmux4way16_stream.sv
// Bench for dmux4way16_stream: directed cases plus a random run checked
// against per-channel queues of accepted, not-yet-drained words.
module tb_dmux4way16_stream;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [7:0]   cnt0, cnt1, cnt2, cnt3;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q [4][$];
  logic [W-1:0] lastd [4];
  int           tot [4];

  always #5 clk = ~clk;

  dmux4way16_stream #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] od(input int i);
    case (i)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      default: return out_data3;
    endcase
  endfunction

  function automatic logic [7:0] oc(input int i);
    case (i)
      0: return cnt0;
      1: return cnt1;
      2: return cnt2;
      default: return cnt3;
    endcase
  endfunction

  function automatic logic [7:0] ecnt(input int i);
`ifdef DMUX4WAY16_STREAM_COUNT_EN
    return 8'(tot[i] % 256);
`else
    return 8'(0 * i);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      lastd[i] = '0;
      tot[i] = 0;
    end
  endtask

  task automatic check_state(input string tag);
    logic [W-1:0] e;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), 32'(out_valid[i]),
          32'(q[i].size() != 0));
      e = (q[i].size() != 0) ? q[i][0] : lastd[i];
      chk($sformatf("%s_data%0d", tag, i), 32'(od(i)), 32'(e));
      chk($sformatf("%s_cnt%0d", tag, i), 32'(oc(i)), 32'(ecnt(i)));
    end
    if (rst)
      chk({tag, "_ready_rst"}, 32'(in_ready), 32'd1);
    else if (!$isunknown(in_sel))
      chk({tag, "_ready"}, 32'(in_ready),
          32'(q[in_sel].size() == 0 || out_ready[in_sel]));
  endtask

  // Inputs are held from 1 after a rising edge through the next one.
  task automatic tick(input string tag);
    logic acc;
    int   s;
    logic [W-1:0] d;
    @(negedge clk);
    check_state(tag);
    acc = !rst && in_valid && !$isunknown(in_sel);
    s = 0;
    if (acc) begin
      s = int'(in_sel);
      acc = (q[s].size() == 0) || out_ready[s];
    end
    d = in_data;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        if (q[i].size() != 0 && out_ready[i])
          lastd[i] = q[i].pop_front();
    end
    if (acc) begin
      q[s].push_back(d);
      lastd[s] = d;
      tot[s]++;
    end
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [W-1:0] d,
                      input string tag);
    in_valid = 1'b1;
    in_sel = s;
    in_data = d;
    tick(tag);
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    tick("rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_sel = '0;
    in_valid = 1'b0;
    out_ready = 4'h0;
    model_reset();
    #1;
    check_state("por");
    chk("por_out_valid", 32'(out_valid), 32'h0);
    in_valid = 1'b1;
    tick("por_tick");
    rst = 1'b0;
    in_valid = 1'b0;
    tick("post_rst");

    // one word to channel 2, then a stalled second word
    out_ready = 4'h0;
    send(2'd2, 16'hABCD, "abcd");
    chk("abcd_valid", 32'(out_valid), 32'h4);
    chk("abcd_data2", 32'(out_data2), 32'hABCD);
    in_valid = 1'b1;
    in_sel = 2'd2;
    in_data = 16'h1234;
    #1;
    chk("abcd_stall_ready", 32'(in_ready), 32'h0);
    tick("abcd_stall");
    chk("abcd_stall_data2", 32'(out_data2), 32'hABCD);
    in_valid = 1'b0;

    out_ready = 4'hF;
    tick("drain_a");
    chk("drain_data2_kept", 32'(out_data2), 32'hABCD);
    chk("drain_valid", 32'(out_valid), 32'h0);

    // back-to-back throughput on channel 2
    out_ready = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_sel = 2'd2;
      in_data = 16'(k);
      #1;
      chk($sformatf("b2b_ready%0d", k), 32'(in_ready), 32'h1);
      tick("b2b");
      chk($sformatf("b2b_data%0d", k), 32'(out_data2), k);
    end
    in_valid = 1'b0;
    out_ready = 4'hF;
    tick("drain_b");

    // channel 0 stalled does not block channel 3
    out_ready = 4'h0;
    send(2'd0, 16'h7777, "ch0_fill");
    in_valid = 1'b1;
    in_sel = 2'd3;
    in_data = 16'h5555;
    #1;
    chk("ch3_ready", 32'(in_ready), 32'h1);
    tick("ch3_send");
    in_valid = 1'b0;
    chk("ch3_data", 32'(out_data3), 32'h5555);
    chk("ch0_kept", 32'(out_data0), 32'h7777);
    chk("ch03_valid", 32'(out_valid), 32'h9);

    // asynchronous reset with out_valid = 0101
    out_ready = 4'hF;
    tick("drain_c");
    out_ready = 4'h0;
    send(2'd0, 16'h1111, "rv0");
    send(2'd2, 16'h2222, "rv2");
    chk("pre_rst_valid", 32'(out_valid), 32'h5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_data0", 32'(out_data0), 32'h0);
    chk("async_data2", 32'(out_data2), 32'h0);
    chk("async_ready", 32'(in_ready), 32'h1);
    model_reset();
    in_valid = 1'b1;
    in_sel = 2'd1;
    in_data = 16'hDEAD;
    tick("rst_no_accept");
    rst = 1'b0;
    in_valid = 1'b0;
    tick("rst_release");
    send(2'd1, 16'hBEEF, "resume");
    chk("resume_data1", 32'(out_data1), 32'hBEEF);

    // 257 words to channel 1 exercises counter wrap
    pulse_reset();
    out_ready = 4'hF;
    for (int k = 0; k < 257; k++) begin
      in_valid = 1'b1;
      in_sel = 2'd1;
      in_data = 16'(k);
      tick("wrap");
    end
    in_valid = 1'b0;
    tick("wrap_end");
`ifdef DMUX4WAY16_STREAM_COUNT_EN
    chk("wrap_cnt1", 32'(cnt1), 32'h1);
`else
    chk("wrap_cnt1", 32'(cnt1), 32'h0);
`endif
    chk("wrap_cnt0", 32'(cnt0), 32'h0);
    chk("wrap_cnt2", 32'(cnt2), 32'h0);
    chk("wrap_cnt3", 32'(cnt3), 32'h0);

    // random traffic; X on in_sel only while in_valid is low
    for (int k = 0; k < 10000; k++) begin
      in_valid = 1'($urandom);
      in_data = 16'($urandom);
      out_ready = 4'($urandom);
      if (!in_valid && ($urandom % 8 == 0))
        in_sel = 2'bxx;
      else
        in_sel = 2'($urandom);
      tick("rnd");
    end

    in_valid = 1'b0;
    in_sel = 2'd0;
    out_ready = 4'hF;
    tick("final_drain");
    tick("final");
    chk("final_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("final_q%0d", i), 32'(q[i].size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
